// File: rtl/intr_pending_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : intr_pending_ctrl_pkg
//  Purpose  : Shared definitions for the interrupt pending controller:
//             FSM state encoding and default source/id widths.
//  Revision : 1.0 - initial release
// ============================================================================
package intr_pending_ctrl_pkg;

  localparam int NUM_SRC_DEF = 4;
  localparam int ID_W_DEF    = 2;

  // 2'd3 is unused; the FSM treats it as illegal and falls back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/intr_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : intr_prio_enc
//  Purpose  : Combinational priority encoder, lowest set index wins.
//  Revision : 1.0 - initial release
// ============================================================================
module intr_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] sel_o,
  output logic         any_o
);

  // Scan from the top down so the lowest-index request overwrites last.
  always_comb begin
    sel_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) sel_o = W'(i);
    end
  end

  assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/intr_pending_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : intr_pending_ctrl
//  Purpose  : Latches synchronized interrupt edge pulses as pending bits,
//             applies an enable mask, and presents the highest-priority
//             enabled source to the core via a req/ack/EOI handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module intr_pending_ctrl
  import intr_pending_ctrl_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_pulse,
  input  logic               mask_wen,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic [NUM_SRC-1:0] mask_q,
  output logic [NUM_SRC-1:0] pend_q,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  output logic               irq_active,
  input  logic               eoi
);

  state_e             state_q;
  logic [NUM_SRC-1:0] w_eligible;
  logic [NUM_SRC-1:0] w_id_onehot;
  logic [NUM_SRC-1:0] pend_d;
  logic [NUM_SRC-1:0] mask_d;
  logic [ID_W-1:0]    w_sel;
  logic               w_any;
  logic               w_ack_take;
  logic               w_req_live;

  // Only registered pending/mask values feed arbitration.
  assign w_eligible = pend_q & mask_q;

  intr_prio_enc #(
    .N (NUM_SRC),
    .W (ID_W)
  ) u_prio_enc (
    .req_i (w_eligible),
    .sel_o (w_sel),
    .any_o (w_any)
  );

  // One-hot of the frozen irq_id; avoids indexing past NUM_SRC when
  // NUM_SRC < 2**ID_W.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_id_onehot
    assign w_id_onehot[i] = (irq_id == ID_W'(i));
  end

  assign w_ack_take = (state_q == ST_REQ) && irq_ack;
  assign w_req_live = |(w_eligible & w_id_onehot);

  // A new pulse wins over the clear from a same-cycle ack, so no edge is lost.
  assign pend_d = (pend_q & ~(w_id_onehot & {NUM_SRC{w_ack_take}})) | src_pulse;
  assign mask_d = mask_wen ? mask_wdata : mask_q;

  // Pending bits and enable mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  // Handshake FSM with registered req/active/id outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      irq_req    <= 1'b0;
      irq_active <= 1'b0;
      irq_id     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_any) begin
            state_q <= ST_REQ;
            irq_req <= 1'b1;
            irq_id  <= w_sel;
          end
        end
        ST_REQ: begin
          // Ack beats withdrawal; irq_id stays frozen while requesting.
          if (irq_ack) begin
            state_q    <= ST_SERVICE;
            irq_req    <= 1'b0;
            irq_active <= 1'b1;
          end else if (!w_req_live) begin
            state_q <= ST_IDLE;
            irq_req <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (eoi) begin
            state_q    <= ST_IDLE;
            irq_active <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          irq_req    <= 1'b0;
          irq_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_intr_pending_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intr_pending_ctrl
//  Purpose  : Self-checking bench for intr_pending_ctrl (vector table plus
//             hand-written reset sequence, scoreboard queue of expectations).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_intr_pending_ctrl;

  typedef struct packed {
    logic [3:0] pulse;
    logic       mwen;
    logic [3:0] mwd;
    logic       ack;
    logic       eoi;
  } in_t;

  typedef struct packed {
    logic [3:0] pend;
    logic [3:0] mask;
    logic       req;
    logic [1:0] id;
    logic       act;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] src_pulse;
  logic       mask_wen;
  logic [3:0] mask_wdata;
  logic [3:0] mask_q;
  logic [3:0] pend_q;
  logic       irq_req;
  logic [1:0] irq_id;
  logic       irq_ack;
  logic       irq_active;
  logic       eoi;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];
  out_t sb[$];

  intr_pending_ctrl #(
    .NUM_SRC (4),
    .ID_W    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_pulse  (src_pulse),
    .mask_wen   (mask_wen),
    .mask_wdata (mask_wdata),
    .mask_q     (mask_q),
    .pend_q     (pend_q),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .irq_active (irq_active),
    .eoi        (eoi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] p, input logic w, input logic [3:0] wd,
                              input logic a, input logic e,
                              input logic [3:0] ep, input logic [3:0] em, input logic er,
                              input logic [1:0] ei, input logic ea);
    vec_t v;
    v.i = '{pulse: p, mwen: w, mwd: wd, ack: a, eoi: e};
    v.o = '{pend: ep, mask: em, req: er, id: ei, act: ea};
    return v;
  endfunction

  task automatic check(input string nm, input out_t exp);
    out_t got;
    got = '{pend: pend_q, mask: mask_q, req: irq_req, id: irq_id, act: irq_active};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got pend=%b mask=%b req=%b id=%0d act=%b, want pend=%b mask=%b req=%b id=%0d act=%b",
               nm, got.pend, got.mask, got.req, got.id, got.act,
               exp.pend, exp.mask, exp.req, exp.id, exp.act);
    end
  endtask

  task automatic idle_inputs();
    src_pulse  = '0;
    mask_wen   = 1'b0;
    mask_wdata = '0;
    irq_ack    = 1'b0;
    eoi        = 1'b0;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input string nm, input in_t vi, input out_t eo);
    out_t e;
    @(negedge clk);
    src_pulse  = vi.pulse;
    mask_wen   = vi.mwen;
    mask_wdata = vi.mwd;
    irq_ack    = vi.ack;
    eoi        = vi.eoi;
    sb.push_back(eo);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(nm, e);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // ---- test 1: basic latency, single source ----
    vecs.push_back(mk(4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0));
    // ---- test 2: priority, frozen id, re-request after eoi ----
    vecs.push_back(mk(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'b1111, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1010, 4'b1111, 1'b1, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1000, 4'b1111, 1'b0, 2'd1, 1'b1));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b1000, 4'b1111, 1'b0, 2'd1, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b1111, 1'b1, 2'd3, 1'b0));
    vecs.push_back(mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1001, 4'b1111, 1'b1, 2'd3, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b1111, 1'b0, 2'd3, 1'b1));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b1111, 1'b0, 2'd3, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b1111, 1'b1, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0));
    // ---- test 3: masked pulse held, released by mask write ----
    vecs.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0));
    // ---- test 4: withdrawal on mask clear, ack beats withdrawal ----
    vecs.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b1));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0));
    // ---- test 5: set beats clear, stray ack/eoi, re-entry ----
    vecs.push_back(mk(4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b1111, 1'b0, 2'd2, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b1111, 1'b1, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b1111, 1'b1, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b1111, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b1111, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b1111, 1'b0, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b1111, 1'b1, 2'd0, 1'b0));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b1));
    vecs.push_back(mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0, 2'd0, 1'b0));

    // ---- reset ----
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", '{pend: 4'b0000, mask: 4'b0000, req: 1'b0, id: 2'd0, act: 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table ----
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      apply($sformatf("vec%0d", k), v.i, v.o);
    end

    // ---- test 6: asynchronous reset during SERVICE with all pending ----
    apply("t6_pulse_all", '{pulse: 4'b1111, mwen: 1'b0, mwd: 4'b0000, ack: 1'b0, eoi: 1'b0},
          '{pend: 4'b1111, mask: 4'b1111, req: 1'b0, id: 2'd0, act: 1'b0});
    apply("t6_req", '{pulse: 4'b0000, mwen: 1'b0, mwd: 4'b0000, ack: 1'b0, eoi: 1'b0},
          '{pend: 4'b1111, mask: 4'b1111, req: 1'b1, id: 2'd0, act: 1'b0});
    apply("t6_ack", '{pulse: 4'b0000, mwen: 1'b0, mwd: 4'b0000, ack: 1'b1, eoi: 1'b0},
          '{pend: 4'b1110, mask: 4'b1111, req: 1'b0, id: 2'd0, act: 1'b1});
    apply("t6_reentry", '{pulse: 4'b0001, mwen: 1'b0, mwd: 4'b0000, ack: 1'b0, eoi: 1'b0},
          '{pend: 4'b1111, mask: 4'b1111, req: 1'b0, id: 2'd0, act: 1'b1});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", '{pend: 4'b0000, mask: 4'b0000, req: 1'b0, id: 2'd0, act: 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    apply("t6_post_idle0", '{pulse: 4'b0000, mwen: 1'b0, mwd: 4'b0000, ack: 1'b0, eoi: 1'b0},
          '{pend: 4'b0000, mask: 4'b0000, req: 1'b0, id: 2'd0, act: 1'b0});
    apply("t6_post_mask", '{pulse: 4'b0000, mwen: 1'b1, mwd: 4'b0010, ack: 1'b0, eoi: 1'b0},
          '{pend: 4'b0000, mask: 4'b0010, req: 1'b0, id: 2'd0, act: 1'b0});
    apply("t6_post_idle1", '{pulse: 4'b0000, mwen: 1'b0, mwd: 4'b0000, ack: 1'b0, eoi: 1'b0},
          '{pend: 4'b0000, mask: 4'b0010, req: 1'b0, id: 2'd0, act: 1'b0});
    apply("t6_new_pulse", '{pulse: 4'b0010, mwen: 1'b0, mwd: 4'b0000, ack: 1'b0, eoi: 1'b0},
          '{pend: 4'b0010, mask: 4'b0010, req: 1'b0, id: 2'd0, act: 1'b0});
    apply("t6_new_req", '{pulse: 4'b0000, mwen: 1'b0, mwd: 4'b0000, ack: 1'b0, eoi: 1'b0},
          '{pend: 4'b0010, mask: 4'b0010, req: 1'b1, id: 2'd1, act: 1'b0});

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
